// File: rtl/mont_pkg.sv
// Shared types and constants for the radix-4 Montgomery multiplier sequencer.
package mont_pkg;

  localparam int unsigned N_BITS_DEF  = 512;
  localparam int unsigned STEPS_DEF   = 256;
  localparam int unsigned MAX_SUB_DEF = 4;

  localparam logic [3:0] PHASE_LAST = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoop,
    StResolve,
    StSub,
    StDone
  } state_t;

  // Quotient digit: (c_flags * m_prime) mod 4, i.e. the low two bits of the product.
  function automatic logic [1:0] q_digit_of(input logic [1:0] c, input logic [1:0] mp);
    logic [1:0] prod;
    prod = c * mp;
    return prod;
  endfunction

endpackage

// File: rtl/mont_phase_cnt.sv
// Chunk-phase counter 0..PHASE_LAST with enable, synchronous clear and a wrap pulse.
module mont_phase_cnt
  import mont_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] phase,
  output logic       wrap
);

  logic [3:0] phase_q;

  assign wrap  = en && (phase_q == PHASE_LAST);
  assign phase = phase_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= wrap ? 4'd0 : phase_q + 4'd1;
    end
  end

endmodule

// File: rtl/mont_ctrl.sv
// Sequencer for the radix-4 Montgomery datapath: double-shift loop, carry resolve,
// then conditional-subtract passes until the adder reports completion or the limit trips.
module mont_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned N_BITS  = N_BITS_DEF,
  parameter int unsigned STEPS   = STEPS_DEF,
  parameter int unsigned MAX_SUB = MAX_SUB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] in_a,
  input  logic [1:0]        m_prime,
  input  logic [1:0]        c_flags,
  input  logic              sub_done,
  output logic [1:0]        a_digit,
  output logic [1:0]        q_digit,
  output logic              c_doubleshift,
  output logic              subtract,
  output logic [3:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned ITER_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned SUB_W  = $clog2(MAX_SUB + 1);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(STEPS - 1);
  localparam logic [SUB_W-1:0]  SUB_LIMIT = SUB_W'(MAX_SUB);

  state_t              state_q;
  logic [N_BITS-1:0]   a_sh_q;
  logic [ITER_W-1:0]   iter_q;
  logic [SUB_W-1:0]    sub_cnt_q;
  logic [SUB_W-1:0]    sub_cnt_inc;
  logic                cnt_en;
  logic                cnt_wrap;

  assign cnt_en      = (state_q == StResolve) || (state_q == StSub);
  assign sub_cnt_inc = sub_cnt_q + SUB_W'(1);

  mont_phase_cnt u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (!cnt_en),
    .phase (phase),
    .wrap  (cnt_wrap)
  );

  // a_sh is zero outside LOOP, so its low digit doubles as the registered a_digit.
  assign a_digit = a_sh_q[1:0];
  assign q_digit = (state_q == StLoop) ? q_digit_of(c_flags, m_prime) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      a_sh_q        <= '0;
      iter_q        <= '0;
      sub_cnt_q     <= '0;
      c_doubleshift <= 1'b0;
      subtract      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_sh_q        <= in_a;
            iter_q        <= '0;
            c_doubleshift <= 1'b1;
            busy          <= 1'b1;
            state_q       <= StLoop;
          end
        end
        StLoop: begin
          a_sh_q <= a_sh_q >> 2;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_LAST) begin
            a_sh_q        <= '0;
            c_doubleshift <= 1'b0;
            state_q       <= StResolve;
          end
        end
        StResolve: begin
          if (cnt_wrap) begin
            sub_cnt_q <= '0;
            subtract  <= 1'b1;
            state_q   <= StSub;
          end
        end
        StSub: begin
          // sub_done only matters on the last chunk of a pass.
          if (cnt_wrap) begin
            if (sub_done) begin
              subtract <= 1'b0;
              done     <= 1'b1;
              state_q  <= StDone;
            end else if (sub_cnt_inc == SUB_LIMIT) begin
              sub_cnt_q <= sub_cnt_inc;
              subtract  <= 1'b0;
              done      <= 1'b1;
              err       <= 1'b1;
              state_q   <= StDone;
            end else begin
              sub_cnt_q <= sub_cnt_inc;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mont_ctrl.md
# mont_ctrl

Sequencer for the radix-4 Montgomery multiplier datapath. It latches operand A and drives the carry-save adder through three phases:
- 256 double-shift iterations;
- a six-chunk carry-resolve pass;
- repeated six-chunk conditional-subtract passes until the adder reports completion.

It sits directly upstream of the mpadder datapath. It generates every control strobe the datapath consumes and returns per-iteration digit selects for the operand-multiple muxes.

## Interface
- N_BITS, 512: operand width.
- STEPS, 256: radix-4 iterations (N_BITS/2).
- MAX_SUB, 4: maximum subtract passes before error.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset. One clock, synchronous active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- in_a  in  N_BITS  multiplier operand A; latched on accepted start.
- m_prime  in  2  −M⁻¹ mod 4; held stable while busy.
- c_flags  in  2  {cOne,cZero} from datapath; low two bits of resolved accumulator + current digit contribution.
- sub_done  in  1  datapath subtract-finished flag (its `carry` output).
- a_digit  out  2  current A digit (selects B0..B3).
- q_digit  out  2  current quotient digit (selects M0..M3).
- c_doubleshift  out  1  accumulator shift/update strobe.
- subtract  out  1  datapath in subtract mode.
- phase  out  4  chunk index 0..5 (datapath showFluffyPonies); 0 outside RESOLVE/SUB.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse; result valid at datapath output.
- err  out  1  one-cycle pulse, with done, when MAX_SUB exceeded.

## Operation
- States: IDLE, LOOP, RESOLVE, SUB, DONE.
- IDLE:
  - all strobes 0.
  - start=1: latch in_a into a_sh, clear iter counter, go LOOP.
- LOOP, one cycle per iteration:
  - a_digit = a_sh[1:0].
  - q_digit = (c_flags · m_prime) mod 4, combinational from c_flags.
  - c_doubleshift=1.
  - a_sh shifts right by 2 with zero fill; iter increments.
  - iter==STEPS−1: go RESOLVE.
- RESOLVE:
  - subtract=0, phase counts 0,1,2,3,4,5.
  - c_doubleshift=0; a_digit=q_digit=0.
  - After phase 5: phase←0, sub_cnt←0, go SUB.
- SUB:
  - subtract=1, phase counts 0..5 repeatedly.
  - sub_done is sampled only at phase==5. A value on sub_done at other phases is ignored.
  - At phase 5 with sub_done=1: go DONE.
  - At phase 5 with sub_done=0: sub_cnt++.
    - sub_cnt reaches MAX_SUB: go DONE with err.
    - Otherwise wrap phase to 0.
- DONE: done=1 (err=1 if the limit was hit) for one cycle; busy=0 in the following cycle; return to IDLE.
- start is ignored while busy. in_a and m_prime changes after acceptance have no effect, except that m_prime must be held.
- Width rules:
  - iter is ⌈log2 STEPS⌉ bits.
  - sub_cnt is ⌈log2(MAX_SUB+1)⌉ bits.
  - q_digit uses only the low 2 bits of the product.

## Timing
- Reset: state=IDLE; all outputs 0; a_sh, iter, sub_cnt, phase cleared.
  - Reset wins over any concurrent start.
  - Mid-operation reset takes effect at that edge: strobes are 0 in the next cycle and nothing completes.
- Accepted start at edge t: LOOP occupies edges t+1..t+STEPS; c_doubleshift is high for exactly STEPS cycles.
- RESOLVE occupies 6 cycles. Each SUB pass occupies 6 cycles.
- Latency, start edge to done-pulse edge: 1 + STEPS + 6 + 6·k + 1, for k subtract passes with k≥1. With defaults and k=1: 270 cycles.
- Start is accepted the cycle after the DONE→IDLE transition. There is no back-to-back acceptance in the DONE cycle.
- Outputs are registered except q_digit, which is combinational from c_flags and m_prime within LOOP and 0 elsewhere.

## Structure
- Package mont_pkg holds:
  - the state enum;
  - PHASE_LAST=5;
  - default N_BITS, STEPS and MAX_SUB constants.
- One sub-module, mont_phase_cnt: a 0..PHASE_LAST counter with enable, sync clear and a wrap pulse. It is reused by RESOLVE and SUB.
- Everything else stays in mont_ctrl.

## Test plan
- Reset/idle: hold rst 3 cycles, then start=0 for 10 cycles -> every output 0 throughout.
- Basic run:
  - Stimulus: in_a=0x…0001B (low digits 3,2,1,0,…), m_prime=3, c_flags=1 constant, sub_done pulsed at the first SUB phase 5.
  - a_digit sequence: 3,2,1,0,0…
  - q_digit=3 every LOOP cycle.
  - c_doubleshift high for 256 cycles.
  - phase sequence 0..5 twice.
  - done exactly 270 cycles after start.
  - err=0.
- Multi-pass subtract: sub_done high at the third phase-5 only -> three SUB passes; done at cycle 282.
- Sub limit: sub_done never asserted -> 4 SUB passes, then done=err=1 at cycle 288; busy drops the next cycle.
- Ignored inputs:
  - start re-pulsed during LOOP and RESOLVE -> no restart; iteration count is unaffected.
  - sub_done=1 at phase 2 -> ignored.
- Reset mid-run: rst asserted at LOOP iteration 100 -> next cycle busy=0 and c_doubleshift=0. A subsequent start produces a full 270-cycle run.
